// File: rtl/regfile_pkg.sv
// Shared types, default sizes and lane-slicing helper for the multiport register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DEPTH  = 64;
  localparam int DEF_NUM_RD = 3;
  localparam int DEF_NUM_WR = 2;

  // LSB position of lane 'lane' inside a packed vector of 'lane_width'-bit lanes.
  function automatic int lane_lsb(input int lane, input int lane_width);
    return lane * lane_width;
  endfunction

endpackage

// File: rtl/multiport_regfile_if.sv
// Bus between the execute stage (master) and the multiport register file (slave).
interface multiport_regfile_if
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
);
  localparam int AW = $clog2(DEPTH);

  logic                    clear_req;
  logic                    ready;
  logic                    conflict;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_WR*AW-1:0]    wr_addr;
  logic [NUM_WR*WIDTH-1:0] wr_data;
  logic [NUM_WR-1:0]       wr_enable;

  modport master (
    output clear_req, rd_addr, wr_addr, wr_data, wr_enable,
    input  ready, rd_data, conflict
  );

  modport slave (
    input  clear_req, rd_addr, wr_addr, wr_data, wr_enable,
    output ready, rd_data, conflict
  );

endinterface

// File: rtl/regfile_write_arbiter.sv
// Resolves the write ports per address: highest enabled port index wins, and
// any address claimed by two or more enabled ports raises conflict.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter  int NUM_WR = DEF_NUM_WR,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int AW     = $clog2(DEPTH),
  localparam int PW     = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR-1:0]        wr_enable,
  output logic [DEPTH-1:0]         hit,
  output logic [DEPTH-1:0][PW-1:0] sel,
  output logic                     conflict
);

  logic [AW-1:0] addr [NUM_WR];

  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_addr
    assign addr[gi] = wr_addr[lane_lsb(gi, AW) +: AW];
  end

  // Walking ports in ascending order lets later (higher) ports overwrite the select.
  always_comb begin
    hit      = '0;
    sel      = '0;
    conflict = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_enable[p]) begin
        if (hit[addr[p]]) conflict = 1'b1;
        hit[addr[p]] = 1'b1;
        sel[addr[p]] = PW'(p);
      end
    end
  end

endmodule

// File: rtl/multiport_regfile.sv
// Parametrised multi-port register file with registered reads and a post-reset clear sequencer.
// Optional write-first bypass of same-cycle writes: define REGFILE_BYPASS_EN.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter int NUM_WR  = DEF_NUM_WR,
  parameter int R0_ZERO = 0
) (
  input logic                clock,
  input logic                reset,
  multiport_regfile_if.slave bus
);

  localparam int            AW   = $clog2(DEPTH);
  localparam int            PW   = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t                      state_reg, state_next;
  logic [AW-1:0]               count_reg, count_next;
  logic                        ready_comb;
  logic [WIDTH-1:0]            mem [DEPTH];
  logic [NUM_WR-1:0][WIDTH-1:0] wr_word;
  logic [NUM_WR-1:0]           wr_live;
  logic [DEPTH-1:0]            hit;
  logic [DEPTH-1:0][PW-1:0]    sel;
  logic                        conflict_now;
  logic [NUM_RD*WIDTH-1:0]     rd_next, rd_data_reg;
  logic                        conflict_reg;

  // Writes only exist in RUN; gating here also keeps conflict and bypass quiet in CLEAR.
  assign wr_live = (state_reg == RUN) ? bus.wr_enable : '0;

  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr
    assign wr_word[gi] = bus.wr_data[lane_lsb(gi, WIDTH) +: WIDTH];
  end

  regfile_write_arbiter #(
    .NUM_WR (NUM_WR),
    .DEPTH  (DEPTH)
  ) u_arbiter (
    .wr_addr   (bus.wr_addr),
    .wr_enable (wr_live),
    .hit       (hit),
    .sel       (sel),
    .conflict  (conflict_now)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= CLEAR;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      CLEAR: begin
        count_next = count_reg + 1'b1;
        if (count_reg == LAST) state_next = RUN;
      end
      RUN: begin
        if (bus.clear_req) begin
          state_next = CLEAR;
          count_next = '0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    ready_comb = (state_reg == RUN);
  end

  // Array storage has no reset; the clear sequencer is what zeroes it.
  always_ff @(posedge clock) begin
    if (state_reg == CLEAR) begin
      mem[count_reg] <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (hit[a] && !(R0_ZERO != 0 && a == 0)) mem[a] <= wr_word[sel[a]];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] word;
    assign ra = bus.rd_addr[lane_lsb(gi, AW) +: AW];
`ifdef REGFILE_BYPASS_EN
    assign word = hit[ra] ? wr_word[sel[ra]] : mem[ra];
`else
    assign word = mem[ra];
`endif
    assign rd_next[lane_lsb(gi, WIDTH) +: WIDTH] = (R0_ZERO != 0 && ra == '0) ? '0 : word;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_reg  <= '0;
      conflict_reg <= 1'b0;
    end else begin
      rd_data_reg  <= (state_reg == RUN) ? rd_next : '0;
      conflict_reg <= conflict_now;
    end
  end

  assign bus.ready    = ready_comb;
  assign bus.rd_data  = rd_data_reg;
  assign bus.conflict = conflict_reg;

endmodule

// File: tb/tb_multiport_regfile.sv
// Bench for multiport_regfile: two instances (R0_ZERO=0 and R0_ZERO=1) share one stimulus stream.
module tb_multiport_regfile;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [2:0][5:0]  ra;
    logic [1:0][5:0]  wa;
    logic [1:0][15:0] wd;
    logic [1:0]       we;
    logic             clr;
    logic [2:0][15:0] exp;
    logic             ec;
  } vec_t;

  typedef struct {
    logic [2:0][15:0] rd;
    logic [2:0][15:0] rdz;
    logic             c;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_xact = 0;
  exp_t sb [$];

  always #5 clock = ~clock;

  multiport_regfile_if #(.WIDTH(16), .DEPTH(64), .NUM_RD(3), .NUM_WR(2)) bus ();
  multiport_regfile_if #(.WIDTH(16), .DEPTH(64), .NUM_RD(3), .NUM_WR(2)) bus_z ();

  assign bus_z.clear_req = bus.clear_req;
  assign bus_z.rd_addr   = bus.rd_addr;
  assign bus_z.wr_addr   = bus.wr_addr;
  assign bus_z.wr_data   = bus.wr_data;
  assign bus_z.wr_enable = bus.wr_enable;

  multiport_regfile #(.WIDTH(16), .DEPTH(64), .NUM_RD(3), .NUM_WR(2), .R0_ZERO(0)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  multiport_regfile #(.WIDTH(16), .DEPTH(64), .NUM_RD(3), .NUM_WR(2), .R0_ZERO(1)) u_dut_z (
    .clock (clock),
    .reset (reset),
    .bus   (bus_z)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bp(input logic [15:0] new_val, input logic [15:0] old_val);
    return BYP ? new_val : old_val;
  endfunction

  function automatic vec_t mk(input int a0, input int a1, input int a2, input logic [1:0] we,
                              input int wa0, input logic [15:0] wd0,
                              input int wa1, input logic [15:0] wd1,
                              input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic ec);
    vec_t v;
    v.ra[0] = 6'(a0); v.ra[1] = 6'(a1); v.ra[2] = 6'(a2);
    v.wa[0] = 6'(wa0); v.wa[1] = 6'(wa1);
    v.wd[0] = wd0; v.wd[1] = wd1;
    v.we = we; v.clr = 1'b0;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
    v.ec = ec;
    return v;
  endfunction

  // Drive at the falling edge, queue the expectation, compare just after the next rising edge.
  task automatic xact(input vec_t v);
    exp_t e;
    @(negedge clock);
    bus.rd_addr   = v.ra;
    bus.wr_addr   = v.wa;
    bus.wr_data   = v.wd;
    bus.wr_enable = v.we;
    bus.clear_req = v.clr;
    e.rd = v.exp;
    for (int i = 0; i < 3; i++) e.rdz[i] = (v.ra[i] == 6'd0) ? 16'h0000 : v.exp[i];
    e.c = v.ec;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk($sformatf("rd_data_x%0d", n_xact), 64'(bus.rd_data), 64'(e.rd));
    chk($sformatf("rd_data_r0z_x%0d", n_xact), 64'(bus_z.rd_data), 64'(e.rdz));
    chk($sformatf("conflict_x%0d", n_xact), 64'(bus.conflict), 64'(e.c));
    chk($sformatf("conflict_r0z_x%0d", n_xact), 64'(bus_z.conflict), 64'(e.c));
    $display("xact %0d ra=%h we=%b wa=%h wd=%h clr=%b rd=%h rd_z=%h conflict=%b",
             n_xact, v.ra, v.we, v.wa, v.wd, v.clr, bus.rd_data, bus_z.rd_data, bus.conflict);
    n_xact++;
  endtask

  task automatic wait_ready(input string name);
    int first = 0;
    bit quiet = 1'b1;
    for (int k = 1; k <= 100 && first == 0; k++) begin
      @(posedge clock);
      #1;
      if (bus.ready && bus_z.ready) first = k;
      else if (bus.ready || bus_z.ready || bus.conflict || bus_z.conflict ||
               bus.rd_data != '0 || bus_z.rd_data != '0) quiet = 1'b0;
    end
    chk({name, "_ready_cycles"}, 64'(first), 64'd64);
    chk({name, "_clear_outputs_quiet"}, 64'(quiet), 64'd1);
    $display("xact %s ready after %0d cycles", name, first);
  endtask

  initial begin
    vec_t tbl [12];
    vec_t v;
    bit   quiet;

    // During the initial clear, drive a conflicting write to r2; it must be ignored.
    bus.clear_req = 1'b0;
    bus.rd_addr   = {6'd2, 6'd2, 6'd2};
    bus.wr_addr   = {6'd2, 6'd2};
    bus.wr_data   = {16'hFFFF, 16'hEEEE};
    bus.wr_enable = 2'b11;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ready", 64'(bus.ready), 64'd0);
    chk("reset_ready_r0z", 64'(bus_z.ready), 64'd0);
    chk("reset_rd_data", 64'(bus.rd_data), 64'd0);
    chk("reset_conflict", 64'(bus.conflict), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    wait_ready("initial");

    for (int a = 0; a < 22; a++) begin
      xact(mk((3 * a) % 64, (3 * a + 1) % 64, (3 * a + 2) % 64, 2'b00, 0, 16'h0, 0, 16'h0,
              16'h0, 16'h0, 16'h0, 1'b0));
    end

    tbl[0]  = mk(1, 2, 1, 2'b11, 1, 16'h0003, 2, 16'h0002,
                 bp(16'h0003, 16'h0), bp(16'h0002, 16'h0), bp(16'h0003, 16'h0), 1'b0);
    tbl[1]  = mk(1, 2, 1, 2'b00, 0, 16'h0, 0, 16'h0, 16'h0003, 16'h0002, 16'h0003, 1'b0);
    tbl[2]  = mk(5, 5, 0, 2'b11, 5, 16'h1111, 5, 16'h2222,
                 bp(16'h2222, 16'h0), bp(16'h2222, 16'h0), 16'h0, 1'b1);
    tbl[3]  = mk(5, 1, 2, 2'b00, 0, 16'h0, 0, 16'h0, 16'h2222, 16'h0003, 16'h0002, 1'b0);
    tbl[4]  = mk(7, 7, 5, 2'b01, 7, 16'hABCD, 0, 16'h0,
                 bp(16'hABCD, 16'h0), bp(16'hABCD, 16'h0), 16'h2222, 1'b0);
    tbl[5]  = mk(7, 0, 63, 2'b00, 0, 16'h0, 0, 16'h0, 16'hABCD, 16'h0, 16'h0, 1'b0);
    tbl[6]  = mk(0, 7, 1, 2'b01, 0, 16'hFFFF, 0, 16'h0,
                 bp(16'hFFFF, 16'h0), 16'hABCD, 16'h0003, 1'b0);
    tbl[7]  = mk(0, 0, 0, 2'b00, 0, 16'h0, 0, 16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    tbl[8]  = mk(9, 8, 10, 2'b10, 9, 16'h5555, 9, 16'h1234,
                 bp(16'h1234, 16'h0), 16'h0, 16'h0, 1'b0);
    tbl[9]  = mk(9, 9, 9, 2'b00, 0, 16'h0, 0, 16'h0, 16'h1234, 16'h1234, 16'h1234, 1'b0);
    tbl[10] = mk(3, 4, 63, 2'b11, 3, 16'h0042, 4, 16'hBEEF,
                 bp(16'h0042, 16'h0), bp(16'hBEEF, 16'h0), 16'h0, 1'b0);
    tbl[11] = mk(3, 4, 5, 2'b00, 0, 16'h0, 0, 16'h0, 16'h0042, 16'hBEEF, 16'h2222, 1'b0);

    for (int i = 0; i < 12; i++) xact(tbl[i]);

    // Clear request, then a reset ten cycles into the clear must restart it.
    v = mk(3, 4, 5, 2'b00, 0, 16'h0, 0, 16'h0, 16'h0042, 16'hBEEF, 16'h2222, 1'b0);
    v.clr = 1'b1;
    xact(v);
    @(negedge clock);
    bus.clear_req = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      if (bus.ready || bus_z.ready || bus.rd_data != '0 || bus_z.rd_data != '0) quiet = 1'b0;
    end
    chk("clear_phase_quiet", 64'(quiet), 64'd1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midclear_reset_ready", 64'(bus.ready), 64'd0);
    chk("midclear_reset_rd_data", 64'(bus.rd_data), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    wait_ready("restart");
    xact(mk(3, 5, 1, 2'b00, 0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0));
    xact(mk(0, 7, 9, 2'b00, 0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
